// File: rtl/alu_issue_stage.sv
// Decode/operand-fetch stage ahead of the 24-bit ALU: 8x24 register file, one-entry issue slot.
// Issue data appears the cycle after accept; instr_ready = slot empty or being popped this cycle.
module alu_issue_stage #(
  parameter int DATA_W = 24,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [23:0]       instr,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  output logic [7:0]        absVal,
  output logic [2:0]        issue_rd,
  output logic              issue_is_mem,
  output logic              jump_valid,
  output logic [DATA_W-1:0] jump_target,
  output logic              illegal
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [3:0] OP_JUMP = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1000;
  localparam logic [3:0] OP_LD   = 4'b1010;
  localparam logic [3:0] OP_ST   = 4'b1011;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic [0:0]        r_state;
  logic [3:0]        r_ctrl;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic [7:0]        r_abs;
  logic [2:0]        r_rd;
  logic              r_is_mem;
  logic [2:0]        r_ra;
  logic [2:0]        r_rb;
  logic              r_jump_valid;
  logic [DATA_W-1:0] r_jump_target;
  logic              r_illegal;

  logic [3:0]        w_op;
  logic [2:0]        w_ry;
  logic [2:0]        w_ra;
  logic [2:0]        w_rb;
  logic [7:0]        w_imm;
  logic              w_is_alu;
  logic              w_is_mem;
  logic              w_is_jump;
  logic              w_is_illegal;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_full;
  logic              w_ready;
  logic              w_accept;
  logic              w_pop;
  logic              w_load;
  logic              w_unused_bits;

  assign w_op          = instr[23:20];
  assign w_ry          = instr[19:17];
  assign w_ra          = instr[16:14];
  assign w_rb          = instr[13:11];
  assign w_imm         = instr[7:0];
  assign w_unused_bits = ^instr[10:8];

  always_comb begin
    w_is_alu     = 1'b0;
    w_is_mem     = 1'b0;
    w_is_jump    = 1'b0;
    w_is_illegal = 1'b0;
    case (w_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110,
      4'b1100, 4'b1101:   w_is_alu     = 1'b1;
      OP_LD, OP_ST:       w_is_mem     = 1'b1;
      OP_JUMP:            w_is_jump    = 1'b1;
      OP_NOP:             ;
      default:            w_is_illegal = 1'b1;
    endcase
  end

  // Operand reads see a same-cycle writeback so no stale value is captured.
  assign w_opa = (wb_en && (wb_addr == w_ra)) ? wb_data : r_regs[w_ra];
  assign w_opb = (wb_en && (wb_addr == w_rb)) ? wb_data : r_regs[w_rb];

  assign w_full   = (r_state == S_FULL);
  assign w_ready  = !w_full || issue_ready;
  assign w_accept = instr_valid && w_ready;
  assign w_pop    = w_full && issue_ready;
  assign w_load   = w_accept && (w_is_alu || w_is_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_ctrl   <= '0;
      r_in1    <= '0;
      r_in2    <= '0;
      r_abs    <= '0;
      r_rd     <= '0;
      r_is_mem <= 1'b0;
      r_ra     <= '0;
      r_rb     <= '0;
    end else if (w_load) begin
      r_state  <= S_FULL;
      r_ctrl   <= w_op;
      r_in1    <= w_opa;
      r_in2    <= w_opb;
      r_abs    <= w_imm;
      r_rd     <= w_is_mem ? w_rb : w_ry;
      r_is_mem <= w_is_mem;
      r_ra     <= w_ra;
      r_rb     <= w_rb;
    end else if (w_pop) begin
      r_state <= S_EMPTY;
    end else if (w_full && wb_en) begin
      // A stalled slot tracks writebacks to its source registers.
      if (wb_addr == r_ra) begin
        r_in1 <= wb_data;
      end
      if (wb_addr == r_rb) begin
        r_in2 <= wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_jump_valid  <= 1'b0;
      r_jump_target <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_jump_valid <= w_accept && w_is_jump;
      r_illegal    <= w_accept && w_is_illegal;
      if (w_accept && w_is_jump) begin
        r_jump_target <= w_opa;
      end
    end
  end

  assign instr_ready  = w_ready;
  assign issue_valid  = w_full;
  assign alu_control  = r_ctrl;
  assign in1          = r_in1;
  assign in2          = r_in2;
  assign absVal       = r_abs;
  assign issue_rd     = r_rd;
  assign issue_is_mem = r_is_mem;
  assign jump_valid   = r_jump_valid;
  assign jump_target  = r_jump_target;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [23:0] wb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  alu_control;
  logic [23:0] in1;
  logic [23:0] in2;
  logic [7:0]  absVal;
  logic [2:0]  issue_rd;
  logic        issue_is_mem;
  logic        jump_valid;
  logic [23:0] jump_target;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .alu_control(alu_control), .in1(in1), .in2(in2), .absVal(absVal),
    .issue_rd(issue_rd), .issue_is_mem(issue_is_mem),
    .jump_valid(jump_valid), .jump_target(jump_target), .illegal(illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [3:0] op, input logic [2:0] ry,
                                     input logic [2:0] ra, input logic [2:0] rb,
                                     input logic [7:0] imm);
    return {op, ry, ra, rb, 3'b000, imm};
  endfunction

  // Reference model: architectural registers plus the issue slot as a queue of at most one entry.
  typedef struct {
    logic [3:0]  ctrl;
    logic [23:0] in1;
    logic [23:0] in2;
    logic [7:0]  abs_v;
    logic [2:0]  rd;
    logic        mem;
    logic [2:0]  ra;
    logic [2:0]  rb;
  } slot_t;

  logic [23:0] m_regs [8];
  slot_t       m_q[$];
  logic        m_jv;
  logic [23:0] m_jt;
  logic        m_ill;

  function automatic bit m_ready(input logic ir);
    return (m_q.size() == 0) || (ir == 1'b1);
  endfunction

  task automatic model_step();
    logic [3:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [23:0] va;
    logic [23:0] vb;
    bit          acc;
    slot_t       s;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 24'h0;
      m_q.delete();
      m_jv  = 1'b0;
      m_jt  = 24'h0;
      m_ill = 1'b0;
    end else begin
      op  = instr[23:20];
      ra  = instr[16:14];
      rb  = instr[13:11];
      va  = (wb_en && wb_addr == ra) ? wb_data : m_regs[ra];
      vb  = (wb_en && wb_addr == rb) ? wb_data : m_regs[rb];
      acc = instr_valid && m_ready(issue_ready);
      if (m_q.size() != 0 && issue_ready) begin
        void'(m_q.pop_front());
      end else if (m_q.size() != 0 && wb_en) begin
        s = m_q[0];
        if (s.ra == wb_addr) s.in1 = wb_data;
        if (s.rb == wb_addr) s.in2 = wb_data;
        m_q[0] = s;
      end
      m_jv  = 1'b0;
      m_ill = 1'b0;
      if (acc) begin
        s.ctrl = op; s.in1 = va; s.in2 = vb; s.abs_v = instr[7:0];
        s.ra = ra; s.rb = rb; s.rd = instr[19:17]; s.mem = 1'b0;
        case (op)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd12, 4'd13: m_q.push_back(s);
          4'd10, 4'd11: begin s.mem = 1'b1; s.rd = rb; m_q.push_back(s); end
          4'd7: begin m_jv = 1'b1; m_jt = va; end
          4'd9, 4'd14, 4'd15: m_ill = 1'b1;
          default: ;
        endcase
      end
      if (wb_en) m_regs[wb_addr] = wb_data;
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [23:0] ins, input logic we,
                       input logic [2:0] wa, input logic [23:0] wd, input logic ir);
    rst = r; instr_valid = iv; instr = ins; wb_en = we; wb_addr = wa; wb_data = wd;
    issue_ready = ir;
    #1;
    chk("instr_ready", {31'b0, instr_ready}, {31'b0, m_ready(ir)});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("issue_valid", {31'b0, issue_valid}, {31'b0, m_q.size() != 0});
    chk("jump_valid", {31'b0, jump_valid}, {31'b0, m_jv});
    chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
    if (m_jv) chk("jump_target", {8'b0, jump_target}, {8'b0, m_jt});
    if (m_q.size() != 0) begin
      chk("alu_control", {28'b0, alu_control}, {28'b0, m_q[0].ctrl});
      chk("in1", {8'b0, in1}, {8'b0, m_q[0].in1});
      chk("in2", {8'b0, in2}, {8'b0, m_q[0].in2});
      chk("absVal", {24'b0, absVal}, {24'b0, m_q[0].abs_v});
      chk("issue_rd", {29'b0, issue_rd}, {29'b0, m_q[0].rd});
      chk("issue_is_mem", {31'b0, issue_is_mem}, {31'b0, m_q[0].mem});
    end
  endtask

  typedef struct {
    logic        rst; logic iv; logic [23:0] ins; logic we; logic [2:0] wa; logic [23:0] wd;
    logic        ir;
    logic        e_iv; logic [3:0] e_ctrl; logic [23:0] e_in1; logic [23:0] e_in2;
    logic [7:0]  e_abs; logic [2:0] e_rd; logic e_mem; logic e_jv; logic [23:0] e_jt;
    logic        e_ill;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  initial begin
    vec_t v;
    logic [3:0] rop;

    tbl[0]  = '{1'b1, 1'b0, 24'h0, 1'b0, 3'd0, 24'h0, 1'b0,
                1'b0, 4'h0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b0, 24'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 24'h0, 1'b1, 3'd1, 24'h000005, 1'b1,
                1'b0, 4'h0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b0, 24'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 24'h0, 1'b1, 3'd2, 24'h000003, 1'b1,
                1'b0, 4'h0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b0, 24'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, mk(4'h0, 3'd3, 3'd1, 3'd2, 8'h00), 1'b0, 3'd0, 24'h0, 1'b0,
                1'b1, 4'h0, 24'h000005, 24'h000003, 8'h00, 3'd3, 1'b0, 1'b0, 24'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 24'h0, 1'b0, 3'd0, 24'h0, 1'b1,
                1'b0, 4'h0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b0, 24'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, mk(4'hC, 3'd5, 3'd4, 3'd0, 8'h7F), 1'b1, 3'd4, 24'h000010, 1'b1,
                1'b1, 4'hC, 24'h000010, 24'h000000, 8'h7F, 3'd5, 1'b0, 1'b0, 24'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, mk(4'h7, 3'd0, 3'd2, 3'd0, 8'h00), 1'b1, 3'd2, 24'h001234, 1'b1,
                1'b0, 4'h0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b1, 24'h001234, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, mk(4'h8, 3'd1, 3'd1, 3'd1, 8'h11), 1'b0, 3'd0, 24'h0, 1'b1,
                1'b0, 4'h0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b0, 24'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, mk(4'hE, 3'd1, 3'd1, 3'd1, 8'h11), 1'b0, 3'd0, 24'h0, 1'b1,
                1'b0, 4'h0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b0, 24'h0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, mk(4'hB, 3'd6, 3'd1, 3'd7, 8'h22), 1'b0, 3'd0, 24'h0, 1'b1,
                1'b1, 4'hB, 24'h000005, 24'h000000, 8'h22, 3'd7, 1'b1, 1'b0, 24'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 24'h0, 1'b0, 3'd0, 24'h0, 1'b1,
                1'b0, 4'h0, 24'h0, 24'h0, 8'h0, 3'd0, 1'b0, 1'b0, 24'h0, 1'b0};

    rst = 1'b1; instr_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    issue_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_step();

    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      drive(v.rst, v.iv, v.ins, v.we, v.wa, v.wd, v.ir);
      tick();
      chk($sformatf("t%0d_issue_valid", i), {31'b0, issue_valid}, {31'b0, v.e_iv});
      chk($sformatf("t%0d_jump_valid", i), {31'b0, jump_valid}, {31'b0, v.e_jv});
      chk($sformatf("t%0d_illegal", i), {31'b0, illegal}, {31'b0, v.e_ill});
      if (v.e_jv) chk($sformatf("t%0d_jump_target", i), {8'b0, jump_target}, {8'b0, v.e_jt});
      if (v.e_iv || v.rst) begin
        chk($sformatf("t%0d_ctrl", i), {28'b0, alu_control}, {28'b0, v.e_ctrl});
        chk($sformatf("t%0d_in1", i), {8'b0, in1}, {8'b0, v.e_in1});
        chk($sformatf("t%0d_in2", i), {8'b0, in2}, {8'b0, v.e_in2});
        chk($sformatf("t%0d_abs", i), {24'b0, absVal}, {24'b0, v.e_abs});
        chk($sformatf("t%0d_rd", i), {29'b0, issue_rd}, {29'b0, v.e_rd});
        chk($sformatf("t%0d_mem", i), {31'b0, issue_is_mem}, {31'b0, v.e_mem});
      end
    end

    // Back-to-back SUBRR with the consumer always ready: no bubble.
    drive(1'b0, 1'b1, mk(4'h1, 3'd3, 3'd1, 3'd2, 8'h00), 1'b0, 3'd0, 24'h0, 1'b1);
    chk("b2b_ready0", {31'b0, instr_ready}, 32'd1);
    tick();
    chk("b2b_iv0", {31'b0, issue_valid}, 32'd1);
    chk("b2b_in1_0", {8'b0, in1}, 32'h000005);
    chk("b2b_in2_0", {8'b0, in2}, 32'h001234);
    drive(1'b0, 1'b1, mk(4'h1, 3'd4, 3'd2, 3'd1, 8'h00), 1'b0, 3'd0, 24'h0, 1'b1);
    chk("b2b_ready1", {31'b0, instr_ready}, 32'd1);
    tick();
    chk("b2b_iv1", {31'b0, issue_valid}, 32'd1);
    chk("b2b_in1_1", {8'b0, in1}, 32'h001234);
    chk("b2b_in2_1", {8'b0, in2}, 32'h000005);
    chk("b2b_rd1", {29'b0, issue_rd}, 32'd4);

    // Stall for five cycles with a writeback to the held ra in the middle.
    drive(1'b0, 1'b1, mk(4'h1, 3'd3, 3'd1, 3'd2, 8'h00), 1'b0, 3'd0, 24'h0, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, mk(4'h0, 3'd5, 3'd5, 3'd5, 8'h00), (k == 2), 3'd1, 24'hABCDEF, 1'b0);
      chk($sformatf("stall%0d_ready", k), {31'b0, instr_ready}, 32'd0);
      tick();
      chk($sformatf("stall%0d_iv", k), {31'b0, issue_valid}, 32'd1);
      chk($sformatf("stall%0d_ctrl", k), {28'b0, alu_control}, 32'd1);
      chk($sformatf("stall%0d_in1", k), {8'b0, in1}, (k >= 2) ? 32'hABCDEF : 32'h000005);
      chk($sformatf("stall%0d_in2", k), {8'b0, in2}, 32'h001234);
    end
    drive(1'b0, 1'b0, 24'h0, 1'b0, 3'd0, 24'h0, 1'b1);
    chk("release_ready", {31'b0, instr_ready}, 32'd1);
    tick();
    chk("release_iv", {31'b0, issue_valid}, 32'd0);

    // Reset while full and stalled drops the slot and clears the register file.
    drive(1'b0, 1'b1, mk(4'h4, 3'd2, 3'd1, 3'd2, 8'h09), 1'b0, 3'd0, 24'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, mk(4'h0, 3'd2, 3'd1, 3'd2, 8'h00), 1'b0, 3'd0, 24'h0, 1'b0);
    tick();
    chk("prerst_iv", {31'b0, issue_valid}, 32'd1);
    drive(1'b1, 1'b0, 24'h0, 1'b0, 3'd0, 24'h0, 1'b0);
    tick();
    chk("rst_iv", {31'b0, issue_valid}, 32'd0);
    chk("rst_in1", {8'b0, in1}, 32'd0);
    chk("rst_in2", {8'b0, in2}, 32'd0);
    drive(1'b0, 1'b1, mk(4'h0, 3'd1, 3'd1, 3'd2, 8'h00), 1'b0, 3'd0, 24'h0, 1'b1);
    tick();
    chk("postrst_iv", {31'b0, issue_valid}, 32'd1);
    chk("postrst_in1", {8'b0, in1}, 32'd0);
    chk("postrst_in2", {8'b0, in2}, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rop = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) < 7),
            {rop, 20'($urandom)},
            ($urandom_range(0, 1) == 1),
            3'($urandom_range(0, 7)),
            24'($urandom),
            ($urandom_range(0, 9) < 6));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
